// File: rtl/instruction_decode_unit.sv
// Purpose : decode stage behind the 4-bit fetch unit; programmable 16-entry ROM,
//           one-cycle control pulses, ALU controls, call-depth tracking.
// Latency : outputs registered one cycle after ISSUE; fixed 2 cycles/instruction
//           (ISSUE, WAIT). No backpressure: fetch unit must follow the pulses.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   pc, zero_flag        fetch address and ALU zero flag, sampled in ISSUE
//   prog_we/addr/data    ROM write port (write at clock edge, read-before-write)
//   write_enable, jump, call, ret, beq_set, bne_set
//                        one-cycle control pulses, exactly one per instruction
//   imm_address, imm_address_jump, imm_address_branch
//                        raw imm field (fetch unit adds +1 to targets)
//   alu_op, rd           ALU controls, held through WAIT
//   halted               level, high while in HALTED
//   stack_err            sticky call-overflow / ret-underflow flag
//
// Build option: define ILLEGAL_TRAP_EN to halt on opcodes 9-E; otherwise they
// decode as NOP.

module instruction_decode_unit #(
    parameter int IW         = 12,
    parameter int CALL_DEPTH = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    pc,
    input  logic          zero_flag,
    input  logic          prog_we,
    input  logic [3:0]    prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic          write_enable,
    output logic          jump,
    output logic          call,
    output logic          ret,
    output logic          beq_set,
    output logic          bne_set,
    output logic [3:0]    imm_address,
    output logic [3:0]    imm_address_jump,
    output logic [3:0]    imm_address_branch,
    output logic [1:0]    alu_op,
    output logic [3:0]    rd,
    output logic          halted,
    output logic          stack_err
);

    localparam int DW = $clog2(CALL_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(CALL_DEPTH);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;
    localparam logic [3:0] OP_RET  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_LDI  = 2'b11;

    typedef enum logic [1:0] {
        S_ISSUE  = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Instruction ROM: not reset, so a program survives reset. The read is
    // combinational from the current contents, so a write landing on the
    // issued address in the same cycle is only seen by the next ISSUE.
    // ------------------------------------------------------------------
    logic [IW-1:0] rom [16];

    always_ff @(posedge clk) begin
        if (!reset && prog_we) begin
            rom[prog_addr] <= prog_data;
        end
    end

    logic [IW-1:0] word;
    logic [3:0]    op_dat;
    logic [3:0]    rd_dat;
    logic [3:0]    imm_dat;

    assign word    = rom[pc];
    assign op_dat  = word[11:8];
    assign rd_dat  = word[7:4];
    assign imm_dat = word[3:0];

    logic op_illegal;
    logic op_halts;

    assign op_illegal = (op_dat >= 4'h9) && (op_dat <= 4'hE);

`ifdef ILLEGAL_TRAP_EN
    assign op_halts = (op_dat == OP_HALT) || op_illegal;
`else
    assign op_halts = (op_dat == OP_HALT);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_ISSUE:  state_nxt = op_halts ? S_HALTED : S_WAIT;
            S_WAIT:   state_nxt = S_ISSUE;
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_ISSUE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Computes the values to register at the coming edge.
    // Pulses default low so they last exactly one cycle; the held fields
    // default to their current value and only change on an ISSUE.
    // ------------------------------------------------------------------
    logic          we_d, jump_d, call_d, ret_d, beq_d, bne_d;
    logic [1:0]    alu_d;
    logic [3:0]    rd_d, imm_d, imm_jump_d, imm_branch_d;
    logic [DW-1:0] depth, depth_d;
    logic          err_d;

    always_comb begin
        we_d         = 1'b0;
        jump_d       = 1'b0;
        call_d       = 1'b0;
        ret_d        = 1'b0;
        beq_d        = 1'b0;
        bne_d        = 1'b0;
        alu_d        = alu_op;
        rd_d         = rd;
        imm_d        = imm_address;
        imm_jump_d   = imm_address_jump;
        imm_branch_d = imm_address_branch;
        depth_d      = depth;
        err_d        = stack_err;

        if (state == S_ISSUE) begin
            alu_d        = ALU_NONE;
            rd_d         = rd_dat;
            imm_d        = imm_dat;
            imm_jump_d   = imm_dat;
            imm_branch_d = imm_dat;

            case (op_dat)
                OP_NOP: we_d = 1'b1;
                OP_ADD: begin
                    we_d  = 1'b1;
                    alu_d = ALU_ADD;
                end
                OP_SUB: begin
                    we_d  = 1'b1;
                    alu_d = ALU_SUB;
                end
                OP_LDI: begin
                    we_d  = 1'b1;
                    alu_d = ALU_LDI;
                end
                OP_JMP: jump_d = 1'b1;
                // A not-taken branch still has to advance the pc.
                OP_BEQ: begin
                    beq_d = zero_flag;
                    we_d  = !zero_flag;
                end
                OP_BNE: begin
                    bne_d = !zero_flag;
                    we_d  = zero_flag;
                end
                // Overflowing CALL / underflowing RET are squashed into a
                // plain pc advance and latch the sticky error.
                OP_CALL: begin
                    if (depth == DEPTH_MAX) begin
                        err_d = 1'b1;
                        we_d  = 1'b1;
                    end else begin
                        depth_d = depth + 1'b1;
                        call_d  = 1'b1;
                    end
                end
                OP_RET: begin
                    if (depth == '0) begin
                        err_d = 1'b1;
                        we_d  = 1'b1;
                    end else begin
                        depth_d = depth - 1'b1;
                        ret_d   = 1'b1;
                    end
                end
                OP_HALT: ;
                default: begin
                    // Opcodes 9-E: trap build halts (handled by op_halts),
                    // otherwise behave as NOP.
                    we_d = !op_illegal || !op_halts;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable       <= 1'b0;
            jump               <= 1'b0;
            call               <= 1'b0;
            ret                <= 1'b0;
            beq_set            <= 1'b0;
            bne_set            <= 1'b0;
            alu_op             <= ALU_NONE;
            rd                 <= 4'h0;
            imm_address        <= 4'h0;
            imm_address_jump   <= 4'h0;
            imm_address_branch <= 4'h0;
            depth              <= '0;
            stack_err          <= 1'b0;
        end else begin
            write_enable       <= we_d;
            jump               <= jump_d;
            call               <= call_d;
            ret                <= ret_d;
            beq_set            <= beq_d;
            bne_set            <= bne_d;
            alu_op             <= alu_d;
            rd                 <= rd_d;
            imm_address        <= imm_d;
            imm_address_jump   <= imm_jump_d;
            imm_address_branch <= imm_branch_d;
            depth              <= depth_d;
            stack_err          <= err_d;
        end
    end

    assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Purpose : self-checking bench for instruction_decode_unit (directed + random).
// Latency : compares every cycle on the falling edge against a behavioural model.
// Backpressure: none; stimulus is driven right after each falling edge.

module tb_instruction_decode_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pc;
    logic        zero_flag;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;
    logic        write_enable, jump, call, ret, beq_set, bne_set;
    logic [3:0]  imm_address, imm_address_jump, imm_address_branch;
    logic [1:0]  alu_op;
    logic [3:0]  rd;
    logic        halted, stack_err;

    always #5 clk = ~clk;

    instruction_decode_unit #(.IW(12), .CALL_DEPTH(15)) dut (
        .clk                (clk),
        .reset              (reset),
        .pc                 (pc),
        .zero_flag          (zero_flag),
        .prog_we            (prog_we),
        .prog_addr          (prog_addr),
        .prog_data          (prog_data),
        .write_enable       (write_enable),
        .jump               (jump),
        .call               (call),
        .ret                (ret),
        .beq_set            (beq_set),
        .bne_set            (bne_set),
        .imm_address        (imm_address),
        .imm_address_jump   (imm_address_jump),
        .imm_address_branch (imm_address_branch),
        .alu_op             (alu_op),
        .rd                 (rd),
        .halted             (halted),
        .stack_err          (stack_err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: tracks "an instruction is in flight" (the WAIT
    // cycle), the halt condition, depth as an integer and a ROM image.
    // ------------------------------------------------------------------
    logic [11:0] m_rom [16];
    bit          m_busy, m_halt, m_err;
    int          m_depth;
    bit          m_we, m_jump, m_call, m_ret, m_beq, m_bne;
    logic [1:0]  m_alu;
    logic [3:0]  m_rd, m_imm;
    int          m_op;
    bit          m_trap;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always @(posedge clk) begin
        {m_we, m_jump, m_call, m_ret, m_beq, m_bne} = '0;
        if (reset) begin
            m_busy = 0; m_halt = 0; m_err = 0; m_depth = 0;
            m_alu = 0; m_rd = 0; m_imm = 0;
        end else begin
            if (m_busy) begin
                m_busy = 0;
            end else if (!m_halt) begin
                m_op   = int'(m_rom[pc][11:8]);
                m_rd   = m_rom[pc][7:4];
                m_imm  = m_rom[pc][3:0];
                m_alu  = (m_op >= 1 && m_op <= 3) ? 2'(m_op) : 2'd0;
                m_trap = (m_op == 15) || (TRAP && m_op >= 9 && m_op <= 14);
                if (m_trap)                      m_halt = 1;
                else if (m_op == 4)              m_jump = 1;
                else if (m_op == 5 && zero_flag) m_beq = 1;
                else if (m_op == 6 && !zero_flag) m_bne = 1;
                else if (m_op == 7 && m_depth < 15) begin m_call = 1; m_depth++; end
                else if (m_op == 8 && m_depth > 0)  begin m_ret = 1;  m_depth--; end
                else begin
                    m_we = 1;
                    if ((m_op == 7) || (m_op == 8)) m_err = 1;
                end
                m_busy = !m_halt;
            end
            if (prog_we) m_rom[prog_addr] = prog_data;
        end
    end

    logic [25:0] dut_vec, exp_vec;
    assign dut_vec = {write_enable, jump, call, ret, beq_set, bne_set, halted, stack_err,
                      alu_op, rd, imm_address, imm_address_jump, imm_address_branch};
    assign exp_vec = {m_we, m_jump, m_call, m_ret, m_beq, m_bne, m_halt, m_err,
                      m_alu, m_rd, m_imm, m_imm, m_imm};

    always @(negedge clk) begin
        if (chk_en) chk("model_cycle", 32'(dut_vec), 32'(exp_vec));
    end

    // ------------------------------------------------------------------
    // Directed scenarios with hand-computed expectations, then random.
    // ------------------------------------------------------------------
    logic [11:0] init_rom [16] = '{12'h325, 12'h509, 12'h703, 12'h800,
                                   12'hA00, 12'hF00, 12'h134, 12'h408,
                                   12'h612, 12'h241, 12'h3A7, 12'h000,
                                   12'h1FF, 12'h50C, 12'h60D, 12'h2E1};

    task automatic do_reset();
        reset = 1'b1;
        step();
        chk("reset_outputs", 32'(dut_vec), 32'd0);
        reset = 1'b0;
    endtask

    int calls;
    logic last_we;

    initial begin
        reset = 1'b1; pc = 4'd0; zero_flag = 1'b0;
        prog_we = 1'b0; prog_addr = 4'd0; prog_data = 12'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = init_rom[i];
            step();
        end
        prog_we = 1'b0;

        // 1/2: reset, then LDI r2,#5 from ROM[0]
        pc = 4'd0;
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        chk("reset_all_zero", 32'(dut_vec), 32'd0);
        reset = 1'b0;
        step();
        chk("ldi_alu_op", 32'(alu_op), 32'd3);
        chk("ldi_rd", 32'(rd), 32'd2);
        chk("ldi_imm", 32'(imm_address), 32'd5);
        chk("ldi_we", 32'(write_enable), 32'd1);
        step();
        chk("wait_we_low", 32'(write_enable), 32'd0);
        chk("wait_alu_held", 32'(alu_op), 32'd3);

        // 3: BEQ #9 taken / not taken
        pc = 4'd1; zero_flag = 1'b1;
        step();
        chk("beq_taken", 32'(beq_set), 32'd1);
        chk("beq_target", 32'(imm_address_branch), 32'd9);
        chk("beq_taken_we", 32'(write_enable), 32'd0);
        step();
        zero_flag = 1'b0;
        step();
        chk("beq_not_taken", 32'(beq_set), 32'd0);
        chk("beq_not_taken_we", 32'(write_enable), 32'd1);
        step();

        // 4: RET underflow, then call overflow
        pc = 4'd3;
        do_reset();
        step();
        chk("ret_underflow_ret", 32'(ret), 32'd0);
        chk("ret_underflow_we", 32'(write_enable), 32'd1);
        chk("ret_underflow_err", 32'(stack_err), 32'd1);
        pc = 4'd2;
        do_reset();
        calls = 0;
        last_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            calls += int'(call);
            last_we = write_enable;
            step();
        end
        chk("call_pulses", 32'(calls), 32'd15);
        chk("call_overflow_we", 32'(last_we), 32'd1);
        chk("call_overflow_err", 32'(stack_err), 32'd1);

        // 5: illegal opcode and HALT
        pc = 4'd4;
        do_reset();
        step();
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_halted", 32'(halted), 32'd1);
        chk("illegal_no_we", 32'(write_enable), 32'd0);
`else
        chk("illegal_halted", 32'(halted), 32'd0);
        chk("illegal_as_nop", 32'(write_enable), 32'd1);
`endif
        pc = 4'd5;
        do_reset();
        step();
        chk("halt_level", 32'(halted), 32'd1);
        pc = 4'd0;
        repeat (5) step();
        chk("halt_sticks", 32'(halted), 32'd1);
        chk("halt_no_pulse", 32'(write_enable), 32'd0);

        // 6: reset during WAIT, then read-before-write
        do_reset();
        step();
        chk("pre_wait_we", 32'(write_enable), 32'd1);
        reset = 1'b1;
        step();
        chk("reset_in_wait", 32'(dut_vec), 32'd0);
        reset = 1'b0;
        step();
        chk("issue_after_reset", 32'(write_enable), 32'd1);
        step();
        pc = 4'd6;
        prog_we = 1'b1; prog_addr = 4'd6; prog_data = 12'h256;
        step();
        prog_we = 1'b0;
        chk("rbw_old_alu", 32'(alu_op), 32'd1);
        chk("rbw_old_rd", 32'(rd), 32'd3);
        step();
        step();
        chk("rbw_new_alu", 32'(alu_op), 32'd2);
        chk("rbw_new_rd", 32'(rd), 32'd5);

        // Random traffic, checked every cycle by the model compare
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) < 4);
            pc        = 4'($urandom_range(0, 15));
            zero_flag = 1'($urandom_range(0, 1));
            prog_we   = ($urandom_range(0, 7) == 0);
            prog_addr = 4'($urandom_range(0, 15));
            prog_data = 12'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
